// File: rtl/discferret_pkg.sv
// Shared definitions for the disc write path: stream byte codes, FSM state
// encoding and the byte-to-interval decode.
package discferret_pkg;

    localparam logic [7:0] WR_CARRY      = 8'h7F;
    localparam logic [7:0] WR_WAIT_INDEX = 8'h80;
    localparam logic [7:0] WR_END        = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREFETCH = 3'd1,
        ST_ARM      = 3'd2,
        ST_WRITE    = 3'd3,
        ST_FLUSH    = 3'd4
    } wr_state_e;

    // Interval in clock ticks for a stream byte. 0x00 behaves as 0x01 and the
    // reserved codes (bit 7 set) become a single-tick no-op.
    function automatic logic [6:0] wr_ticks(input logic [7:0] b);
        if (b[7] || (b[6:0] == 7'd0)) begin
            return 7'd1;
        end
        return b[6:0];
    endfunction

endpackage

// File: rtl/write_pulse_gen.sv
// Write pulse stretcher: holds the active-low write data line low for
// PULSE_WIDTH cycles after a start; a new start reloads the width.
module write_pulse_gen #(
    parameter int PULSE_WIDTH = 10
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic start_i,
    input  logic kill_i,
    output logic wrdata_n_o,
    output logic busy_o
);

    localparam logic [5:0] PW = 6'(PULSE_WIDTH);

    logic [5:0] cnt_q, cnt_d;
    logic       low_q, low_d;

    always_comb begin
        cnt_d = cnt_q;
        low_d = low_q;
        if (kill_i) begin
            cnt_d = 6'd0;
            low_d = 1'b0;
        end else if (start_i) begin
            cnt_d = PW;
            low_d = 1'b1;
        end else if (cnt_q != 6'd0) begin
            cnt_d = cnt_q - 6'd1;
            low_d = (cnt_q != 6'd1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= 6'd0;
            low_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            low_q <= low_d;
        end
    end

    assign wrdata_n_o = ~low_q;
    assign busy_o     = low_q;

endmodule

// File: rtl/disc_writer.sv
// Disc write engine: prefetches timing bytes from SRAM, decodes them into
// flux-transition intervals and drives the drive's write data and write gate.
module disc_writer
    import discferret_pkg::*;
#(
    parameter int PULSE_WIDTH = 10,
    parameter int SYNC_STAGES = 2
) (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic       START,
    input  logic       ABORT,
    input  logic       START_ON_INDEX,
    input  logic       FD_INDEX_IN,
    input  logic       FD_WRPROT_IN,
    output logic       MEM_RD_REQ,
    input  logic       MEM_RD_ACK,
    input  logic [7:0] MEM_DATA,
    input  logic       MEM_END,
    output logic       FD_WRDATA,
    output logic       FD_WRGATE,
    output logic       WRITING,
    output logic       ERR_UNDERRUN,
    output logic       ERR_WRPROT
);

    logic [SYNC_STAGES-1:0] idx_sync_q, wp_sync_q;
    logic                   idx_prev_q;
    logic                   idx_event, wp_active;

    wr_state_e  state_q, state_d;
    logic [6:0] cnt_q, cnt_d;
    logic [7:0] cur_q, cur_d;
    logic [7:0] nxt_q, nxt_d;
    logic       nxt_valid_q, nxt_valid_d;
    logic       end_seen_q, end_seen_d;
    logic       req_q, req_d;
    logic       gate_q, gate_d;
    logic       writing_q, writing_d;
    logic       err_u_q, err_u_d;
    logic       err_w_q, err_w_d;

    logic pulse_start, kill, do_load, terminal, in_run, pulse_busy;

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            idx_sync_q <= '1;
            wp_sync_q  <= '1;
            idx_prev_q <= 1'b1;
        end else begin
            idx_sync_q[0] <= FD_INDEX_IN;
            wp_sync_q[0]  <= FD_WRPROT_IN;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                idx_sync_q[i] <= idx_sync_q[i-1];
                wp_sync_q[i]  <= wp_sync_q[i-1];
            end
            idx_prev_q <= idx_sync_q[SYNC_STAGES-1];
        end
    end

    assign idx_event = idx_prev_q & ~idx_sync_q[SYNC_STAGES-1];
    assign wp_active = ~wp_sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cur_d       = cur_q;
        nxt_d       = nxt_q;
        nxt_valid_d = nxt_valid_q;
        end_seen_d  = end_seen_q;
        err_u_d     = err_u_q;
        err_w_d     = err_w_q;
        pulse_start = 1'b0;
        kill        = 1'b0;
        do_load     = 1'b0;
        terminal    = 1'b0;

        // A fetch only lands in the buffer while a request is outstanding
        // and a write is in progress; late acknowledges fall through.
        if (MEM_RD_ACK && req_q && (state_q != ST_IDLE)) begin
            nxt_d       = MEM_DATA;
            nxt_valid_d = 1'b1;
            if (MEM_DATA == WR_END) begin
                end_seen_d = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (START && !ABORT) begin
                    err_u_d = 1'b0;
                    err_w_d = 1'b0;
                    if (wp_active) begin
                        err_w_d = 1'b1;
                    end else begin
                        state_d = ST_PREFETCH;
                    end
                end
            end
            ST_PREFETCH: begin
                if (nxt_valid_q) begin
                    state_d = ST_ARM;
                end else if (MEM_END) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ARM: begin
                if (!START_ON_INDEX || idx_event) begin
                    do_load = 1'b1;
                end
            end
            ST_WRITE: begin
                terminal = (cur_q == WR_WAIT_INDEX) ? idx_event : (cnt_q == 7'd1);
                if (terminal) begin
                    pulse_start = ~cur_q[7] && (cur_q != WR_CARRY);
                    if (nxt_valid_q) begin
                        do_load = 1'b1;
                    end else begin
                        err_u_d = err_u_q | ~MEM_END;
                        state_d = ST_FLUSH;
                    end
                end else if (cur_q != WR_WAIT_INDEX) begin
                    cnt_d = cnt_q - 7'd1;
                end
            end
            ST_FLUSH: begin
                if (!pulse_busy) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (do_load) begin
            cur_d       = nxt_q;
            cnt_d       = wr_ticks(nxt_q);
            nxt_valid_d = 1'b0;
            state_d     = (nxt_q == WR_END) ? ST_FLUSH : ST_WRITE;
        end

        if (state_q != ST_IDLE) begin
            if (wp_active) begin
                err_w_d = 1'b1;
                kill    = 1'b1;
                state_d = ST_IDLE;
            end
            if (ABORT) begin
                kill    = 1'b1;
                state_d = ST_IDLE;
            end
        end

        // Whatever path leads back to IDLE, the next write starts with an empty buffer.
        if (state_d == ST_IDLE) begin
            nxt_valid_d = 1'b0;
            end_seen_d  = 1'b0;
        end
    end

    assign in_run = (state_d == ST_PREFETCH) || (state_d == ST_ARM) || (state_d == ST_WRITE);

    always_comb begin
        req_d = 1'b0;
        if (in_run) begin
            req_d = req_q ? ~MEM_RD_ACK
                          : (~nxt_valid_d & ~end_seen_d & ~MEM_END);
        end
        gate_d    = ~((state_d == ST_ARM) || (state_d == ST_WRITE) || (state_d == ST_FLUSH));
        writing_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 7'd0;
            cur_q       <= 8'd0;
            nxt_q       <= 8'd0;
            nxt_valid_q <= 1'b0;
            end_seen_q  <= 1'b0;
            req_q       <= 1'b0;
            gate_q      <= 1'b1;
            writing_q   <= 1'b0;
            err_u_q     <= 1'b0;
            err_w_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cur_q       <= cur_d;
            nxt_q       <= nxt_d;
            nxt_valid_q <= nxt_valid_d;
            end_seen_q  <= end_seen_d;
            req_q       <= req_d;
            gate_q      <= gate_d;
            writing_q   <= writing_d;
            err_u_q     <= err_u_d;
            err_w_q     <= err_w_d;
        end
    end

    write_pulse_gen #(
        .PULSE_WIDTH(PULSE_WIDTH)
    ) u_pulse (
        .clk_i      (CLOCK),
        .rst_i      (RESET),
        .start_i    (pulse_start),
        .kill_i     (kill),
        .wrdata_n_o (FD_WRDATA),
        .busy_o     (pulse_busy)
    );

    assign MEM_RD_REQ   = req_q;
    assign FD_WRGATE    = gate_q;
    assign WRITING      = writing_q;
    assign ERR_UNDERRUN = err_u_q;
    assign ERR_WRPROT   = err_w_q;

endmodule

// File: tb/tb_disc_writer.sv
// Scoreboarded bench for disc_writer: expected write-data and write-gate edges,
// timed relative to the START edge, are queued and matched by a monitor.
module tb_disc_writer;

    localparam int EV_PF = 0, EV_PR = 1, EV_GF = 2, EV_GR = 3;

    logic       CLOCK = 1'b0, RESET = 1'b1, START = 1'b0, ABORT = 1'b0;
    logic       START_ON_INDEX = 1'b0, FD_INDEX_IN = 1'b1, FD_WRPROT_IN = 1'b1;
    logic       MEM_RD_ACK = 1'b0, MEM_END = 1'b0;
    logic [7:0] MEM_DATA = 8'h00;
    logic       MEM_RD_REQ, FD_WRDATA, FD_WRGATE, WRITING, ERR_UNDERRUN, ERR_WRPROT;

    disc_writer #(.PULSE_WIDTH(10), .SYNC_STAGES(2)) dut (
        .CLOCK(CLOCK), .RESET(RESET), .START(START), .ABORT(ABORT),
        .START_ON_INDEX(START_ON_INDEX), .FD_INDEX_IN(FD_INDEX_IN),
        .FD_WRPROT_IN(FD_WRPROT_IN), .MEM_RD_REQ(MEM_RD_REQ),
        .MEM_RD_ACK(MEM_RD_ACK), .MEM_DATA(MEM_DATA), .MEM_END(MEM_END),
        .FD_WRDATA(FD_WRDATA), .FD_WRGATE(FD_WRGATE), .WRITING(WRITING),
        .ERR_UNDERRUN(ERR_UNDERRUN), .ERR_WRPROT(ERR_WRPROT)
    );

    always #5 CLOCK = ~CLOCK;

    typedef struct {int kind; int rel;} ev_t;
    ev_t  exp_q[$];
    int   n_vec = 0, n_bad = 0, cyc = 0, t0 = 0;
    logic [7:0] mem [0:15];
    int   mem_len = 0, addr = 0, ack_limit = 1000;
    bit   mem_end_en = 1'b1, req_seen = 1'b0;
    logic wr_p = 1'b1, g_p = 1'b1;

    always @(posedge CLOCK) cyc <= cyc + 1;

    function automatic string ev_name(int k);
        case (k)
            EV_PF:   return "wrdata_fall";
            EV_PR:   return "wrdata_rise";
            EV_GF:   return "wrgate_fall";
            default: return "wrgate_rise";
        endcase
    endfunction

    task automatic check(string name, logic [31:0] got, logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end else begin
            $display("ok   %s = %0h", name, got);
        end
    endtask

    task automatic observe(int kind);
        ev_t e;
        int  rel;
        rel = cyc - t0;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL event: got %s at +%0d want none", ev_name(kind), rel);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.rel != rel) begin
                n_bad++;
                $display("FAIL event: got %s at +%0d want %s at +%0d",
                         ev_name(kind), rel, ev_name(e.kind), e.rel);
            end else begin
                $display("ok   event %s at +%0d", ev_name(kind), rel);
            end
        end
    endtask

    // Monitor: every output edge is matched against the scoreboard.
    initial begin
        forever begin
            @(negedge CLOCK);
            if (FD_WRDATA !== wr_p) begin
                observe(FD_WRDATA ? EV_PR : EV_PF);
                wr_p = FD_WRDATA;
            end
            if (FD_WRGATE !== g_p) begin
                observe(FD_WRGATE ? EV_GR : EV_GF);
                g_p = FD_WRGATE;
            end
            if (MEM_RD_REQ === 1'b1) req_seen = 1'b1;
        end
    end

    // SRAM model: acknowledges a request one cycle after it is seen.
    initial begin
        forever begin
            @(negedge CLOCK);
            if (MEM_RD_ACK) begin
                MEM_RD_ACK = 1'b0;
            end else if (MEM_RD_REQ && addr < ack_limit && addr < mem_len) begin
                MEM_DATA   = mem[addr];
                addr       = addr + 1;
                MEM_RD_ACK = 1'b1;
            end
            MEM_END = mem_end_en && (addr >= mem_len);
        end
    end

    task automatic set_stream(input logic [63:0] bytes, input int n);
        for (int i = 0; i < n; i++) mem[i] = bytes[8*(n-1-i) +: 8];
        mem_len = n;
        addr    = 0;
    endtask

    task automatic expect_ev(int kind, int rel);
        ev_t e;
        e.kind = kind;
        e.rel  = rel;
        exp_q.push_back(e);
    endtask

    task automatic start_write();
        @(negedge CLOCK);
        START = 1'b1;
        t0    = cyc + 1;
        @(negedge CLOCK);
        START = 1'b0;
    endtask

    task automatic wait_until(int rel);
        while (cyc < t0 + rel) @(negedge CLOCK);
    endtask

    task automatic finish_test(string name);
        int i;
        i = 0;
        while (WRITING !== 1'b0 && i < 2000) begin
            @(negedge CLOCK);
            i++;
        end
        check({name, " idle"}, 32'(WRITING), 32'd0);
        repeat (3) @(negedge CLOCK);
        check({name, " pending events"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        repeat (3) @(negedge CLOCK);
        check("reset wrdata", 32'(FD_WRDATA), 32'd1);
        check("reset wrgate", 32'(FD_WRGATE), 32'd1);
        check("reset req", 32'(MEM_RD_REQ), 32'd0);
        check("reset writing", 32'(WRITING), 32'd0);
        check("reset err_underrun", 32'(ERR_UNDERRUN), 32'd0);
        check("reset err_wrprot", 32'(ERR_WRPROT), 32'd0);
        RESET = 1'b0;
        repeat (2) @(negedge CLOCK);

        // 05,05,FF: second pulse starts mid-pulse and reloads the width.
        set_stream(64'h0505FF, 3);
        expect_ev(EV_GF, 2); expect_ev(EV_PF, 8); expect_ev(EV_PR, 23); expect_ev(EV_GR, 24);
        start_write();
        check("t1 writing", 32'(WRITING), 32'd1);
        finish_test("t1");
        check("t1 err_underrun", 32'(ERR_UNDERRUN), 32'd0);
        check("t1 err_wrprot", 32'(ERR_WRPROT), 32'd0);

        // Carries: one pulse 270 ticks after the first load.
        set_stream(64'h7F7F10FF, 4);
        expect_ev(EV_GF, 2); expect_ev(EV_PF, 273); expect_ev(EV_PR, 283); expect_ev(EV_GR, 284);
        start_write();
        finish_test("t2");

        // Start on index, then an index wait mid-stream.
        START_ON_INDEX = 1'b1;
        set_stream(64'h208010FF, 4);
        expect_ev(EV_GF, 2); expect_ev(EV_PF, 535); expect_ev(EV_PR, 545);
        expect_ev(EV_PF, 819); expect_ev(EV_PR, 829); expect_ev(EV_GR, 830);
        start_write();
        wait_until(500); FD_INDEX_IN = 1'b0;
        wait_until(520); FD_INDEX_IN = 1'b1;
        wait_until(800); FD_INDEX_IN = 1'b0;
        wait_until(820); FD_INDEX_IN = 1'b1;
        finish_test("t3");
        START_ON_INDEX = 1'b0;

        // Underrun: only the first byte is ever acknowledged.
        ack_limit  = 1;
        mem_end_en = 1'b0;
        set_stream(64'h0405FF, 3);
        expect_ev(EV_GF, 2); expect_ev(EV_PF, 7); expect_ev(EV_PR, 17); expect_ev(EV_GR, 18);
        start_write();
        finish_test("t4");
        check("t4 err_underrun", 32'(ERR_UNDERRUN), 32'd1);
        check("t4 wrgate", 32'(FD_WRGATE), 32'd1);
        repeat (200) @(negedge CLOCK);
        ack_limit  = 1000;
        mem_end_en = 1'b1;

        // Write protected at START.
        FD_WRPROT_IN = 1'b0;
        repeat (4) @(negedge CLOCK);
        set_stream(64'h05FF, 2);
        req_seen = 1'b0;
        start_write();
        repeat (5) @(negedge CLOCK);
        check("t5 err_wrprot", 32'(ERR_WRPROT), 32'd1);
        check("t5 err_underrun cleared", 32'(ERR_UNDERRUN), 32'd0);
        check("t5 wrgate", 32'(FD_WRGATE), 32'd1);
        check("t5 req seen", 32'(req_seen), 32'd0);
        check("t5 writing", 32'(WRITING), 32'd0);
        FD_WRPROT_IN = 1'b1;
        repeat (4) @(negedge CLOCK);

        // Write protect asserted mid-write.
        set_stream(64'h7F7FFF, 3);
        expect_ev(EV_GF, 2); expect_ev(EV_GR, 53);
        start_write();
        check("t6 err_wrprot cleared", 32'(ERR_WRPROT), 32'd0);
        wait_until(50); FD_WRPROT_IN = 1'b0;
        finish_test("t6");
        check("t6 err_wrprot", 32'(ERR_WRPROT), 32'd1);
        FD_WRPROT_IN = 1'b1;
        repeat (4) @(negedge CLOCK);

        // RESET mid-pulse.
        set_stream(64'h087FFF, 3);
        expect_ev(EV_GF, 2); expect_ev(EV_PF, 11); expect_ev(EV_PR, 15); expect_ev(EV_GR, 15);
        start_write();
        wait_until(14);
        #1 RESET = 1'b1;
        #1;
        check("t7 reset wrdata", 32'(FD_WRDATA), 32'd1);
        check("t7 reset wrgate", 32'(FD_WRGATE), 32'd1);
        check("t7 reset req", 32'(MEM_RD_REQ), 32'd0);
        @(negedge CLOCK);
        @(negedge CLOCK);
        RESET = 1'b0;
        finish_test("t7");

        // ABORT mid-pulse, then a fresh START must not reuse the old buffer.
        set_stream(64'h087FFF, 3);
        expect_ev(EV_GF, 2); expect_ev(EV_PF, 11); expect_ev(EV_PR, 15); expect_ev(EV_GR, 15);
        start_write();
        wait_until(14); ABORT = 1'b1;
        @(negedge CLOCK); ABORT = 1'b0;
        check("t8 abort req", 32'(MEM_RD_REQ), 32'd0);
        check("t8 abort wrdata", 32'(FD_WRDATA), 32'd1);
        check("t8 abort wrgate", 32'(FD_WRGATE), 32'd1);
        finish_test("t8");
        set_stream(64'h06FF, 2);
        expect_ev(EV_GF, 2); expect_ev(EV_PF, 9); expect_ev(EV_PR, 19); expect_ev(EV_GR, 20);
        start_write();
        finish_test("t9");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
